spi_sp_ram: RTL

//   Single-port synchronous RAM that executes 10-bit command words delivered by the SPI slave.
//   - din[9:8] is the opcode; din[7:0] is the address or data byte.
//   - Read data is returned as an 8-bit byte with a held tx_valid, which the slave shifts out on MISO.
//   - Sits directly downstream of the SPI slave: consumes rx_data/rx_valid, produces tx_data/tx_valid.

---
 rtl/spi_sp_ram.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_sp_ram.sv
// -----------------------------------------------------------------------------
// spi_sp_ram
//   Single-port synchronous RAM driven by 10-bit command words from an SPI
//   slave. The upper two bits of each word select the operation, the lower
//   eight carry an address or a data byte. Read data is presented on dout and
//   qualified by tx_valid, which stays high until the next accepted command so
//   the slave can shift it out at its own pace.
//
//   Opcodes (din[9:8]):
//     00 WR_ADDR : load the write address register
//     01 WR_DATA : write din[7:0] to mem[wr_addr] (address not incremented)
//     10 RD_ADDR : load the read address register
//     11 RD_DATA : dout <= mem[rd_addr], tx_valid <= 1
//
// Parameters
//   MEM_DEPTH : number of 8-bit words, MEM_DEPTH <= 2**ADDR_SIZE
//   ADDR_SIZE : address width taken from din[ADDR_SIZE-1:0], ADDR_SIZE <= 8
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (memory contents are retained)
//   din      : command word (rx_data from the SPI slave)
//   rx_valid : din valid, level signal; only its rising edge starts a command
//   dout     : read data (tx_data to the SPI slave)
//   tx_valid : dout valid, held until the next accepted command
// -----------------------------------------------------------------------------
module spi_sp_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // One extra bit so that MEM_DEPTH == 2**ADDR_SIZE is representable and the
  // range comparison never wraps.
  localparam logic [ADDR_SIZE:0] DEPTH_LIMIT = (ADDR_SIZE + 1)'(MEM_DEPTH);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_t;

  logic [7:0]           mem [0:MEM_DEPTH-1];

  logic [ADDR_SIZE-1:0] wr_addr_reg;
  logic [ADDR_SIZE-1:0] rd_addr_reg;
  logic                 rx_valid_d_reg;
  logic [7:0]           dout_reg;
  tx_state_t            state_reg;
  tx_state_t            state_next;

  logic                 accept;
  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] addr_field;
  logic                 wr_in_range;
  logic                 rd_in_range;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  // Commands fire on the rising edge of rx_valid only, so a level held high
  // executes once and din changes under a held level are ignored. rst_n is
  // folded in so nothing (in particular the non-reset memory) is touched
  // while reset is asserted; when reset releases with rx_valid still high,
  // rx_valid_d is 0 and the pending command executes once.
  assign accept      = rx_valid & ~rx_valid_d_reg & rst_n;
  assign opcode      = din[9:8];
  assign addr_field  = din[ADDR_SIZE-1:0];

  assign wr_in_range = ({1'b0, wr_addr_reg} < DEPTH_LIMIT);
  assign rd_in_range = ({1'b0, rd_addr_reg} < DEPTH_LIMIT);

  // ---------------------------------------------------------------------------
  // Edge detector and address registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d_reg <= 1'b0;
    end else begin
      rx_valid_d_reg <= rx_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_reg <= '0;
      rd_addr_reg <= '0;
    end else if (accept) begin
      if (opcode == OP_WR_ADDR) begin
        wr_addr_reg <= addr_field;
      end
      if (opcode == OP_RD_ADDR) begin
        rd_addr_reg <= addr_field;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset so contents survive rst_n. Writes to addresses beyond
  // MEM_DEPTH are dropped rather than aliased onto a valid word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && (opcode == OP_WR_DATA) && wr_in_range) begin
      mem[wr_addr_reg] <= din[7:0];
    end
  end

  // Read data register: loads only on RD_DATA, otherwise keeps its last value
  // (including after tx_valid drops). Out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= 8'h00;
    end else if (accept && (opcode == OP_RD_DATA)) begin
      if (rd_in_range) begin
        dout_reg <= mem[rd_addr_reg];
      end else begin
        dout_reg <= 8'h00;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output qualifier FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= TX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Every accepted command decides the next state on its own: RD_DATA
  // (re)enters the hold state, anything else releases it. Without an accept
  // the state is simply kept.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      if (opcode == OP_RD_DATA) begin
        state_next = TX_HOLD;
      end else begin
        state_next = TX_IDLE;
      end
    end
  end

  assign tx_valid = (state_reg == TX_HOLD);
  assign dout     = dout_reg;

endmodule
